// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add multiply sequencer driving an external combinational ALU
module alu_mul_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               prod_z,
   output logic               prod_ovf,
   output logic [2:0]         alu_func,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic [WIDTH-1:0]   alu_r,
   input  logic               alu_c
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0]       FUNC_ADD = 3'b000;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]         state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   acc_hi;
   logic [CNT_W-1:0]   count;

   // {carry, sum, multiplier} shifted right by one; the consumed multiplier
   // bit falls off the bottom and the ALU carry becomes the new MSB.
   logic [2*WIDTH-1:0] shifted;

   assign shifted = {alu_c, alu_r, mplier[WIDTH-1:1]};

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   // ALU operands: accumulate the multiplicand only when the current multiplier bit is set
   always_comb begin
      alu_func = FUNC_ADD;
      alu_a    = '0;
      alu_b    = '0;
      if (state == S_CALC) begin
         alu_a = acc_hi;
         alu_b = mplier[0] ? mcand : '0;
      end
   end

   // Sequencer state, partial product and registered result/flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         mcand    <= '0;
         mplier   <= '0;
         acc_hi   <= '0;
         count    <= '0;
         product  <= '0;
         prod_z   <= 1'b1;
         prod_ovf <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand  <= a_in;
                  mplier <= b_in;
                  acc_hi <= '0;
                  count  <= '0;
                  state  <= S_CALC;
               end
            end
            S_CALC: begin
               acc_hi <= shifted[2*WIDTH-1:WIDTH];
               mplier <= shifted[WIDTH-1:0];
               count  <= count + CNT_ONE;
               if (count == CNT_LAST) begin
                  state    <= S_DONE;
                  product  <= shifted;
                  prod_z   <= (shifted == '0);
                  prod_ovf <= |shifted[2*WIDTH-1:WIDTH];
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Sequencing initiator for the 16-bit ALU. Drives the ALU's func/a/b inputs and consumes its r/c outputs to compute an unsigned WIDTH x WIDTH -> 2*WIDTH product by shift-and-add.
- Sits beside the ALU in the datapath and serves multiply requests through a start/busy/done handshake.
- Adds no adder of its own; all addition goes through the external ALU.

Parameters:
- WIDTH, 16, operand width; must equal the ALU data width.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request pulse; sampled only when busy=0
- a_in  input  WIDTH  multiplicand, sampled with start
- b_in  input  WIDTH  multiplier, sampled with start
- busy  output  1  high in CALC and DONE states
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  unsigned result, held until next accepted start
- prod_z  output  1  product == 0
- prod_ovf  output  1  product[2*WIDTH-1:WIDTH] != 0 (does not fit WIDTH bits)
- alu_func  output  3  ALU opcode; always 3'b000 (ADD)
- alu_a  output  WIDTH  ALU operand a
- alu_b  output  WIDTH  ALU operand b
- alu_r  input  WIDTH  ALU result
- alu_c  input  1  ALU carry-out

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, product=0, prod_z=1, prod_ovf=0, internal regs (mcand, acc_hi, mplier, count) = 0. Reset mid-CALC aborts the operation. No done is produced for the aborted request.
- ALU drive is combinational from registered state:
  - alu_func=ADD in all states.
  - CALC: alu_a=acc_hi; alu_b = mplier[0] ? mcand : 0.
  - IDLE/DONE: alu_a=0, alu_b=0.
- The ALU is combinational. {alu_c, alu_r} is consumed in the same cycle it is driven.
- IDLE:
  - If start=1 at a rising edge: mcand<=a_in, mplier<=b_in, acc_hi<=0, count<=0, state<=CALC.
  - If start=0: outputs hold.
- CALC (exactly WIDTH cycles):
  - Each edge: {acc_hi, mplier} <= {alu_c, alu_r, mplier} >> 1. This is a (2*WIDTH+1)-bit right shift; the bit shifted out of mplier[0] is discarded.
  - count<=count+1.
  - When count==WIDTH-1 at the edge: state<=DONE, and product/prod_z/prod_ovf are loaded from the final shifted value.
- DONE (1 cycle): done=1, busy=1; next edge state<=IDLE, done<=0.
- Latency: start sampled at edge E0; CALC covers edges E1..E16; done=1 in the cycle after E16. That is 17 cycles from start acceptance to done. Throughput is one multiply per 18 cycles minimum.
- start while busy=1 (CALC or DONE) is ignored; no queuing. a_in and b_in are don't-care except at acceptance.
- Back-to-back: start may be asserted on the cycle busy returns to 0. It is accepted and the previous product holds until the new done.
- prod_z and prod_ovf are registered together with product. They never glitch between done pulses.
- Carry: a carry from ADD becomes the new MSB of acc_hi via the shift, so no carry is lost. 0xFFFF*0xFFFF must be exact.
- alu_z and alu_n are not used.

Test Plan:
- Reset, then start a_in=3, b_in=5 → done exactly 17 cycles after acceptance; product=0x0000000F, prod_z=0, prod_ovf=0.
- a_in=0xFFFF, b_in=0xFFFF → product=0xFFFE0001, prod_ovf=1. Check alu_a/alu_b each CALC cycle against the shift-add model; carry from ALU must propagate.
- a_in=0x1234, b_in=0 → every CALC cycle alu_b=0; product=0, prod_z=1. Then a_in=0x8000, b_in=2 → product=0x00010000, prod_ovf=1, prod_z=0.
- start pulsed again at cycles 5 and 17 after acceptance with other operands → ignored. Single done; product matches the first operands only.
- Assert rst at CALC cycle 8 → immediately busy=0, product=0, prod_z=1. No done follows. A new start 7*9 after release → product=63.
- Back-to-back: second start on the first cycle busy=0 → accepted. First product holds until second done; second done exactly 17 cycles after its acceptance.
